// File: rtl/nios_lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nios_lcd_ctrl_if
// Brief    : Avalon-MM slave bus bundle (register access + interrupt) for the
//            character-LCD controller.
// Revision : 1.0 - initial release
// ============================================================================
interface nios_lcd_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    // Host / CPU side
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    // Peripheral side
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/nios_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios_lcd_ctrl
// Brief    : HD44780-style LCD write controller. Avalon writes queue
//            {rs, byte} entries; a sequencer replays each entry as a
//            setup / enable-pulse / hold / execute-wait cycle on the LCD pins.
// Revision : 1.0 - initial release
// ============================================================================
module nios_lcd_ctrl #(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int FIFO_DEPTH    = 4      // power of two, >= 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    nios_lcd_ctrl_if.slave    bus,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CNT_W = ($clog2(LONG_EXEC_CYC) > 17) ? $clog2(LONG_EXEC_CYC) : 17;

    localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] C_LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic             long_q, long_d;
    logic             irq_q, irq_d;
    logic             irq_en_q, irq_en_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [8:0]       mem_q [FIFO_DEPTH];

    logic             wr_en, wr_queue, flush, push, pop;
    logic             fifo_full, fifo_empty, busy;
    logic [8:0]       head, push_entry;
    logic [2:0]       count3;
    logic [31:0]      rd_data;
    logic             wd_unused;

    // Bus decode: addresses 0 (DATA, rs=1) and 1 (CMD, rs=0) feed the queue
    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_queue   = wr_en & ~bus.address[1];
    assign flush      = wr_en & (bus.address == 2'd3) & bus.writedata[1];
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == S_IDLE) & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted
    assign push       = wr_queue & (~fifo_full | pop);
    assign head       = mem_q[rd_ptr_q];
    assign push_entry = {~bus.address[0], bus.writedata[7:0]};
    assign busy       = (state_q != S_IDLE) | ~fifo_empty;
    assign count3     = 3'(count_q);
    assign wd_unused  = ^bus.writedata[31:8];

    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_en     = lcd_en_q;
    assign lcd_rw     = 1'b0;
    assign bus.irq    = irq_q;
    assign bus.readdata = rd_data;

    // Zero-wait-state register read mux
    always_comb begin
        rd_data = '0;
        case (bus.address)
            2'd2:    rd_data = {26'b0, ovf_q, count3, fifo_full, busy};
            2'd3:    rd_data = {31'b0, irq_en_q};
            default: rd_data = '0;
        endcase
    end

    // Queue pointers, occupancy, sticky overflow and control register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        // Flush empties the queue and overrides a same-cycle push
        if (flush) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
        if (wr_queue && fifo_full && !pop)            ovf_d = 1'b1;
        if (wr_en && (bus.address == 2'd2))           ovf_d = 1'b0;
        if (wr_en && (bus.address == 2'd3))           irq_en_d = bus.writedata[0];
    end

    // Sequencer next state, duration counter and LCD output registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        long_d     = long_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    lcd_rs_d   = head[8];
                    lcd_data_d = head[7:0];
                    // Clear-display and return-home need the long execute time
                    long_d     = ~head[8] & ((head[7:0] == 8'h01) | (head[7:0] == 8'h02));
                    state_d    = S_SETUP;
                    cnt_d      = C_SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = C_PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = C_HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = long_q ? C_LONG_LD : C_EXEC_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered strobes: enable follows the next state, irq the present one
    always_comb begin
        lcd_en_d = (state_d == S_PULSE);
        irq_d    = irq_en_q & (state_q == S_IDLE) & fifo_empty;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lcd_data_q <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            long_q     <= 1'b0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
            long_q     <= long_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_lcd_ctrl
// Brief    : Directed self-checking bench for nios_lcd_ctrl (short execute
//            waits so the long-command path fits a short run).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_lcd_ctrl;
    localparam int EXEC = 40;
    localparam int LONG = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en;
    int          total = 0;
    int          bad   = 0;

    nios_lcd_ctrl_if bus ();

    nios_lcd_ctrl #(
        .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(2),
        .EXEC_CYC(EXEC), .LONG_EXEC_CYC(LONG), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        v = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    // Wait (bounded) for lcd_en to rise, then count its high cycles
    task automatic count_pulse(output int n);
        int g;
        g = 0;
        while (!lcd_en && g < 100) begin tick(); g++; end
        n = 0;
        while (lcd_en && n < 100) begin n++; tick(); end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        logic [31:0] s;
        int g;
        g = 0;
        rd(2'd2, s);
        while (s[0] && g < bound) begin tick(); g++; rd(2'd2, s); end
        check({tag, "_idle"}, s, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;
        int          errs;

        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(3);

        // Reset state
        check("rst_en",   lcd_en,   0);
        check("rst_rs",   lcd_rs,   0);
        check("rst_data", lcd_data, 0);
        check("rst_rw",   lcd_rw,   0);
        check("rst_irq",  bus.irq,  0);
        rd(2'd2, v); check("rst_status", v, 32'h0);
        rd(2'd3, v); check("rst_ctrl",   v, 32'h0);
        reset = 1'b0;
        tick();

        // write_n low without chipselect must not enqueue
        bus.address = 2'd1; bus.writedata = 32'h38; bus.write_n = 1'b0;
        tick();
        bus.write_n = 1'b1;
        rd(2'd2, v); check("no_cs_status", v, 32'h0);

        // CMD 0x38: data next cycle, 12-cycle pulse from write+3, short wait
        wr(2'd1, 32'h38);
        rd(2'd2, v); check("cmd_status", v, 32'h5);
        rd(2'd0, v); check("data_read0", v, 32'h0);
        rd(2'd1, v); check("cmd_read0",  v, 32'h0);
        tick();
        check("cmd_rs",    lcd_rs,   0);
        check("cmd_data",  lcd_data, 8'h38);
        check("cmd_setup_en", lcd_en, 0);
        tick(2);
        check("cmd_en_rise", lcd_en, 1);
        count_pulse(n);
        check("cmd_pulse_len", n, 12);
        tick();
        check("cmd_hold_en",   lcd_en,   0);
        check("cmd_hold_data", lcd_data, 8'h38);
        tick(40);
        rd(2'd2, v); check("cmd_busy_last", v, 32'h1);
        tick();
        rd(2'd2, v); check("cmd_busy_end",  v, 32'h0);

        // CMD 0x01 takes the long wait, then queued DATA 0x41 follows
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h41);
        tick(316);
        check("long_data_held", lcd_data, 8'h01);
        check("long_rs_held",   lcd_rs,   0);
        tick();
        check("next_data", lcd_data, 8'h41);
        check("next_rs",   lcd_rs,   1);
        wait_idle(200, "after41");

        // Overflow: long CMD 0x02 then five DATA writes back to back
        wr(2'd1, 32'h02);
        wr(2'd0, 32'h30);
        wr(2'd0, 32'h31);
        wr(2'd0, 32'h32);
        wr(2'd0, 32'h33);
        wr(2'd0, 32'h34);
        rd(2'd2, v); check("ovf_status", v, 32'h33);
        wr(2'd2, 32'h0);
        rd(2'd2, v); check("ovf_cleared", v, 32'h13);
        tick(311);
        check("long2_data_held", lcd_data, 8'h02);
        tick();
        check("fifo_head_data", lcd_data, 8'h30);
        check("fifo_head_rs",   lcd_rs,   1);
        rd(2'd2, v); check("three_queued", v, 32'h0D);

        // Flush with three queued: in-flight 0x30 still completes
        wr(2'd3, 32'h2);
        rd(2'd2, v); check("flush_status", v, 32'h1);
        rd(2'd3, v); check("flush_ctrl_rd", v, 32'h0);
        count_pulse(n);
        check("flush_pulse_len", n, 12);
        check("flush_data", lcd_data, 8'h30);
        wait_idle(200, "flush");
        errs = 0;
        repeat (20) begin if (lcd_en !== 1'b0) errs++; tick(); end
        check("flush_no_more_en", errs, 0);
        check("flush_data_kept", lcd_data, 8'h30);

        // Interrupt: high when idle and empty, low through two transfers
        wr(2'd3, 32'h1);
        tick();
        check("irq_idle", bus.irq, 1);
        rd(2'd3, v); check("ctrl_irq_en", v, 32'h1);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'h66);
        errs = 0;
        repeat (113) begin if (bus.irq !== 1'b0) errs++; tick(); end
        check("irq_low_busy", errs, 0);
        check("irq_last_data", lcd_data, 8'h66);
        check("irq_still_low", bus.irq, 0);
        tick();
        check("irq_back", bus.irq, 1);

        // Reset during PULSE aborts the transfer and drops the queue
        wr(2'd0, 32'h77);
        wr(2'd0, 32'h78);
        tick(2);
        check("pre_rst_en", lcd_en, 1);
        reset = 1'b1;
        #1;
        check("async_rst_en",   lcd_en,   0);
        check("async_rst_data", lcd_data, 0);
        check("async_rst_irq",  bus.irq,  0);
        rd(2'd2, v); check("async_rst_status", v, 32'h0);
        rd(2'd3, v); check("async_rst_ctrl",   v, 32'h0);
        tick(2);
        reset = 1'b0;
        errs = 0;
        repeat (100) begin if (lcd_en !== 1'b0) errs++; tick(); end
        check("post_rst_no_en", errs, 0);
        rd(2'd2, v); check("post_rst_status", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
